// File: rtl/sbox_table_if.sv
// Stream bundle between the S-box generator, the pixel source and sbox_table.
// The master drives entries, reload and pixels; the slave (sbox_table) returns status and substituted bytes.
interface sbox_table_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 sbox_tvalid;
    logic [BIT_WIDTH-1:0] V_in;
    logic                 reload;
    logic                 sbox_ready;
    logic                 px_tvalid;
    logic [BIT_WIDTH-1:0] px_in;
    logic                 px_tready;
    logic                 inv_mode;
    logic                 px_valid;
    logic [BIT_WIDTH-1:0] px_out;

    modport master (
        output sbox_tvalid, V_in, reload, px_tvalid, px_in, inv_mode,
        input  sbox_ready, px_tready, px_valid, px_out
    );

    modport slave (
        input  sbox_tvalid, V_in, reload, px_tvalid, px_in, inv_mode,
        output sbox_ready, px_tready, px_valid, px_out
    );
endinterface

// File: rtl/sbox_table.sv
// Fills a 2^BIT_WIDTH S-box table from the generator stream, then substitutes pixels through it.
// Define SBOX_INVERSE_EN to also build the inverse table, selected per pixel by inv_mode.
module sbox_table #(
    parameter int BIT_WIDTH = 8
) (
    input logic         clk,
    input logic         reset,
    sbox_table_if.slave sb
);
    localparam int DEPTH = 2 ** BIT_WIDTH;

    typedef enum logic {
        LOAD,
        READY
    } state_e;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                 px_valid_q, px_valid_d;
    logic [BIT_WIDTH-1:0] px_out_q, px_out_d;
    logic [BIT_WIDTH-1:0] table_q [DEPTH];
    logic [BIT_WIDTH-1:0] rd_data;
    logic                 wr_en;
    logic                 px_acc;
    logic                 last_beat;

    // reload wins over both a table write and a pixel accept in the same cycle
    assign wr_en     = (state_q == LOAD)  && sb.sbox_tvalid && !sb.reload;
    assign px_acc    = (state_q == READY) && sb.px_tvalid   && !sb.reload;
    assign last_beat = wr_en && (&wr_ptr_q);

    // NOTE: the table carries no reset so it can map onto RAM; its contents are rewritten on every fill anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_ptr_q] <= sb.V_in;
        end
    end

`ifdef SBOX_INVERSE_EN
    logic [BIT_WIDTH-1:0] inv_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inv_q[sb.V_in] <= wr_ptr_q;
        end
    end

    assign rd_data = sb.inv_mode ? inv_q[sb.px_in] : table_q[sb.px_in];
`else
    logic unused_inv_mode;

    assign unused_inv_mode = sb.inv_mode;
    assign rd_data         = table_q[sb.px_in];
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            wr_ptr_q   <= '0;
            px_valid_q <= 1'b0;
            px_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            px_valid_q <= px_valid_d;
            px_out_q   <= px_out_d;
        end
    end

    // Next state: the pointer wraps to 0 naturally on the final beat
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        if (sb.reload) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (last_beat) begin
                        state_d = READY;
                    end
                end
                READY:   state_d = READY;
                default: state_d = LOAD;
            endcase
        end
    end

    // Registered lookup: px_out holds its last value between accepts
    always_comb begin
        px_valid_d = px_acc;
        px_out_d   = px_acc ? rd_data : px_out_q;
    end

    // Outputs
    always_comb begin
        sb.sbox_ready = (state_q == READY);
        sb.px_tready  = (state_q == READY);
        sb.px_valid   = px_valid_q;
        sb.px_out     = px_out_q;
    end
endmodule

// File: tb/tb_sbox_table.sv
// Directed bench for sbox_table: fills tables from known sequences and scoreboards substituted pixels.
// Expected pixel results are queued when driven and compared when px_valid appears.
module tb_sbox_table;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    logic [7:0] exp_q [$];

    sbox_table_if #(.BIT_WIDTH(8)) bus ();

    sbox_table #(.BIT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every px_valid cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && bus.px_valid === 1'b1) begin
            valid_cnt++;
            check("px_valid_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("px_out", bus.px_out, exp_q.pop_front());
            end
        end
    end

    // mode 0: (i*7+3) mod 256, mode 1: 255-i, mode 2: filler bytes
    task automatic fill(input int mode, input int n, input bit gaps, input bit px_probe);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 64) == 63) begin
                bus.sbox_tvalid = 1'b0;
                bus.V_in        = 8'hEE;
                tick();
            end
            if (px_probe && i == 10) begin
                bus.px_tvalid = 1'b1;
                bus.px_in     = 8'h10;
            end
            if (px_probe && i == 20) begin
                bus.px_tvalid = 1'b0;
            end
            bus.sbox_tvalid = 1'b1;
            case (mode)
                0:       bus.V_in = 8'((i * 7 + 3) % 256);
                1:       bus.V_in = 8'(255 - i);
                default: bus.V_in = 8'(i ^ 8'h5A);
            endcase
            tick();
            check($sformatf("sbox_ready_beat%0d", i), bus.sbox_ready, (i == 255));
            if (px_probe && i == 15) begin
                check("px_tready_load", bus.px_tready, 0);
            end
        end
        bus.sbox_tvalid = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] px, input logic inv, input logic [7:0] exp);
        bus.px_tvalid = 1'b1;
        bus.px_in     = px;
        bus.inv_mode  = inv;
        exp_q.push_back(exp);
        tick();
    endtask

    task automatic idle(input int n);
        bus.px_tvalid   = 1'b0;
        bus.sbox_tvalid = 1'b0;
        bus.reload      = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.sbox_tvalid = 1'b0;
        bus.V_in        = '0;
        bus.reload      = 1'b0;
        bus.px_tvalid   = 1'b0;
        bus.px_in       = '0;
        bus.inv_mode    = 1'b0;
        reset           = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_sbox_ready", bus.sbox_ready, 0);
        check("reset_px_tready", bus.px_tready, 0);
        check("reset_px_valid", bus.px_valid, 0);
        check("reset_px_out", bus.px_out, 0);

        // First table, with gaps and a pixel probe that must be ignored during LOAD
        fill(0, 256, 1'b1, 1'b1);
        check("px_tready_ready", bus.px_tready, 1);
        check("no_px_during_load", valid_cnt, 0);

        send_px(8'h00, 1'b0, 8'h03);
        send_px(8'h01, 1'b0, 8'h0A);
        send_px(8'hFF, 1'b0, 8'hFC);
        idle(1);
        check("px_valid_drops", bus.px_valid, 0);
        check("px_out_holds", bus.px_out, 8'hFC);
        idle(2);
        check("px_valid_count", valid_cnt, 3);

        // Extra generator beats in READY must not touch the table
        bus.V_in        = 8'hAA;
        bus.sbox_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.sbox_tvalid = 1'b0;
        send_px(8'h00, 1'b0, 8'h03);
        send_px(8'h02, 1'b0, 8'h11);
        idle(2);

`ifdef SBOX_INVERSE_EN
        send_px(8'h0A, 1'b1, 8'h01);
        send_px(8'h01, 1'b0, 8'h0A);
        send_px(8'hFC, 1'b1, 8'hFF);
        idle(2);
`endif

        // reload together with a pixel: no output, back to LOAD
        bus.reload    = 1'b1;
        bus.px_tvalid = 1'b1;
        bus.px_in     = 8'h00;
        tick();
        bus.reload    = 1'b0;
        bus.px_tvalid = 1'b0;
        check("reload_sbox_ready", bus.sbox_ready, 0);
        check("reload_px_valid", bus.px_valid, 0);
        check("reload_px_tready", bus.px_tready, 0);

        // Partial fill discarded by reset, then a full descending table
        fill(2, 100, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_reset_ready", bus.sbox_ready, 0);
        fill(1, 256, 1'b0, 1'b0);
        send_px(8'h05, 1'b0, 8'hFA);
        send_px(8'h00, 1'b0, 8'hFF);
        idle(2);

        // Refill after reload returns to READY with the new contents
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        check("reload2_sbox_ready", bus.sbox_ready, 0);
        fill(0, 256, 1'b0, 1'b0);
        send_px(8'hFF, 1'b0, 8'hFC);
        send_px(8'h05, 1'b0, 8'h26);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sbox_table.md
Name: sbox_table

Overview:
- Downstream consumer of sbox_generator's V_out stream.
- Collects 2^BIT_WIDTH generated S-box entries in arrival order into an internal table; once full, substitutes streamed pixel bytes through it.
- Sits between the S-box generation chain (PRNG -> sbox_generator) and the later diffusion stage of the image cipher.

Parameters:
- BIT_WIDTH, 8, width of S-box entries and pixel bytes.
- DEPTH, 2**BIT_WIDTH, number of table entries; derived, not overridden.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sbox_tvalid  input  1  V_in carries a valid generated entry this cycle.
- V_in  input  BIT_WIDTH  S-box entry from sbox_generator (registered V_out).
- reload  input  1  discard the current table and return to LOAD.
- sbox_ready  output  1  table complete; pixel path is live.
- px_tvalid  input  1  px_in valid this cycle.
- px_in  input  BIT_WIDTH  pixel byte to substitute.
- px_tready  output  1  equals sbox_ready; pixel accepted when px_tvalid & px_tready.
- inv_mode  input  1  selects the inverse table (used only with SBOX_INVERSE_EN).
- px_valid  output  1  px_out valid this cycle.
- px_out  output  BIT_WIDTH  substituted byte.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=LOAD, wr_ptr=0.
  - sbox_ready=0, px_valid=0, px_out=0.
  - Table contents are not cleared and are don't-care until rewritten.
- FSM has two states, LOAD and READY.
- LOAD:
  - Each cycle with sbox_tvalid=1: table[wr_ptr]<=V_in, wr_ptr<=wr_ptr+1.
  - On the write at wr_ptr=DEPTH-1: next state READY, sbox_ready<=1 on the same edge, wr_ptr wraps to 0.
  - sbox_tvalid=0 cycles hold wr_ptr; gaps are allowed.
  - px_tvalid is ignored; px_tready=0.
- READY:
  - sbox_tvalid is ignored; the table is frozen and extra generator output is dropped.
  - Accepted pixel: px_out<=table[px_in], px_valid<=1 on the next edge. Latency is exactly 1 cycle.
  - No accept that cycle: px_valid<=0 and px_out holds its last value.
  - Back-to-back accepts give one output per cycle, with no bubbles.
- reload=1 (either state):
  - Next state LOAD, wr_ptr<=0, sbox_ready<=0, px_valid<=0.
  - reload has priority over any simultaneous sbox_tvalid write or pixel accept; neither takes effect that cycle.
- Reset mid-LOAD: partial fill is discarded and the fill restarts at entry 0.
- The block does no duplicate or bijectivity check on V_in; uniqueness is the generator's responsibility.
- Table: DEPTH x BIT_WIDTH register array or inferred RAM. Reads in READY are registered.

Optional Feature:
- Macro: SBOX_INVERSE_EN.
- Defined:
  - A second DEPTH x BIT_WIDTH table is written in parallel during LOAD: inv[V_in]<=wr_ptr.
  - In READY, inv_mode=1 gives px_out<=inv[px_in] and inv_mode=0 gives the forward table. Latency is unchanged (1 cycle).
  - inv_mode is sampled with the pixel accept.
- Undefined:
  - No inverse table is built and inv_mode is ignored; the forward table is always used.
  - Port list is unchanged.

Test Plan:
- Reset, then drive 256 sbox_tvalid beats with V_in=(i*7+3) mod 256 -> sbox_ready rises on the edge of beat 255 and not before; px_tready=0 throughout LOAD.
- After fill, px_in=0x00,0x01,0xFF back-to-back -> px_out=0x03,0x0A,0xFC on consecutive cycles, each 1 cycle after accept; px_valid=1 for exactly 3 cycles.
- During LOAD, assert px_tvalid with px_in=0x10 -> no px_valid; after fill, extra sbox_tvalid beats with V_in=0xAA -> table[0] still 0x03.
- After 100 beats assert reset, then feed 256 beats of V_in=255-i -> px_in=0x05 gives px_out=0xFA.
- In READY, assert reload together with px_tvalid -> no px_valid and sbox_ready=0 next cycle; a new 256-beat fill gets READY again.
- With SBOX_INVERSE_EN and the first table: inv_mode=1, px_in=0x0A -> px_out=0x01; inv_mode=0, px_in=0x01 -> 0x0A.
